// File: rtl/axi_rd_burst_slave.sv
// rtl/axi_rd_burst_slave.sv - AXI read-burst slave: AR queue, one memory fetch per beat, SLVERR for illegal bursts
// Define AXI_RD_WRAP_EN to accept WRAP bursts; otherwise WRAP is answered with SLVERR beats.
module axi_rd_burst_slave #(
  parameter int IDW   = 12,
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           mem_req,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_rvalid
);
  localparam int         PW       = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
  } ar_t;

  ar_t            q_mem [DEPTH];
  logic [PW:0]    wr_ptr_q, rd_ptr_q;
  logic           q_full, q_empty, push, pop, head_legal;
  ar_t            head;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [AW-1:0]  beat_addr_q, beat_addr_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]  step, incr_addr, next_addr;
  logic           last_beat;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign s_axi_arready = resetn && !q_full;
  assign push    = s_axi_arvalid && s_axi_arready;
  assign pop     = (state_q == IDLE) && !q_empty;
  assign head    = q_mem[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q[PW-1:0]] <= '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                                   size: s_axi_arsize, burst: s_axi_arburst};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    head_legal = (head.size <= MAX_SIZE) && (head.burst != 2'b11);
`ifdef AXI_RD_WRAP_EN
    if ((head.burst == 2'b10) && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15})) head_legal = 1'b0;
`else
    if (head.burst == 2'b10) head_legal = 1'b0;
`endif
  end

  assign step      = {{(AW-1){1'b0}}, 1'b1} << size_q;
  assign incr_addr = beat_addr_q + step;

`ifdef AXI_RD_WRAP_EN
  logic [AW-1:0] wrap_len, wrap_mask;
  // Legal wrap lengths are powers of two, so the window is a simple mask.
  assign wrap_len  = (AW'(len_q) + {{(AW-1){1'b0}}, 1'b1}) << size_q;
  assign wrap_mask = wrap_len - {{(AW-1){1'b0}}, 1'b1};
`endif

  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = beat_addr_q;
`ifdef AXI_RD_WRAP_EN
      2'b10:   next_addr = (beat_addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default: next_addr = incr_addr;
    endcase
  end

  assign last_beat = (beat_cnt_q == len_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_addr_q <= '0;
      beat_cnt_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_addr_q <= beat_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_addr_d = beat_addr_q;
    beat_cnt_d  = beat_cnt_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          id_d        = head.id;
          len_d       = head.len;
          size_d      = head.size;
          burst_d     = head.burst;
          beat_addr_d = head.addr;
          beat_cnt_d  = '0;
          state_d     = head_legal ? REQ : ERR;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (s_axi_rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d  = beat_cnt_q + 8'd1;
            beat_addr_d = next_addr;
            state_d     = REQ;
          end
        end
      end
      ERR: begin
        if (s_axi_rready) begin
          if (last_beat) state_d = IDLE;
          else           beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_axi_rvalid = (state_q == RESP) || (state_q == ERR);
  assign s_axi_rresp  = (state_q == ERR) ? 2'b10 : 2'b00;
  assign s_axi_rdata  = (state_q == RESP) ? rdata_q : '0;
  assign s_axi_rid    = id_q;
  assign s_axi_rlast  = s_axi_rvalid && last_beat;
  assign mem_req      = (state_q == REQ);
  assign mem_addr     = beat_addr_q;

endmodule

// File: doc/axi_rd_burst_slave.md
AXI_RD_BURST_SLAVE -- requirements
Module: axi_rd_burst_slave

Interface
REQ-001 SHALL have parameter IDW, default 12, meaning AR/R ID width.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter DW, default 64, meaning data width; allowed values 32, 64 and 128.
REQ-004 SHALL have parameter DEPTH, default 4, meaning outstanding-AR queue depth; power of 2, minimum 2.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  global clock; resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have AR channel ports: s_axi_arid in IDW; s_axi_araddr in AW; s_axi_arlen in 8; s_axi_arsize in 3; s_axi_arburst in 2; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-007 SHALL have R channel ports: s_axi_rid out IDW; s_axi_rdata out DW; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-008 SHALL have memory-side ports: mem_req out 1 (one-cycle beat request); mem_addr out AW (beat address); mem_rdata in DW; mem_rvalid in 1 (data valid, arbitrary latency of 1 or more cycles after mem_req).

Function
REQ-009 SHALL set s_axi_arready = !queue_full; an AR handshake pushes {id, addr, len, size, burst} into the DEPTH-entry queue.
REQ-010 SHALL allow a push and a pop in the same cycle; occupancy is unchanged and there is no data loss.
REQ-011 SHALL implement the FSM states IDLE, REQ, WAIT, RESP and ERR.
REQ-012 SHALL, in IDLE with the queue non-empty, pop the head and load beat_addr=addr, beat_cnt=0. A legal burst goes to REQ; an illegal burst goes to ERR.
REQ-013 SHALL, in REQ, assert mem_req=1 with mem_addr=beat_addr for exactly one cycle, then go to WAIT.
REQ-014 SHALL, in WAIT, capture mem_rdata on mem_rvalid and go to RESP. mem_rvalid in any other state SHALL be ignored.
REQ-015 SHALL, in RESP, hold s_axi_rvalid=1, rresp=OKAY(00) and rid=stored id, with rdata stable until s_axi_rready.
REQ-016 SHALL, on an R handshake in RESP, return to IDLE if beat_cnt==len; otherwise increment beat_cnt, advance beat_addr and go to REQ.
REQ-017 SHALL assert s_axi_rlast iff s_axi_rvalid and beat_cnt==len.
REQ-018 SHALL compute the next beat address as follows: FIXED(00) unchanged; INCR(01) beat_addr + (1<<size), truncated to AW bits with wrap-around at 2^AW.
REQ-019 SHALL treat as illegal any burst with size > log2(DW/8), and any burst with burst==11 (reserved).
REQ-020 SHALL, in ERR, emit len+1 beats with rresp=SLVERR(10), rdata=0 and correct rlast, never asserting mem_req, then return to IDLE.
REQ-021 SHALL achieve a minimum latency, with mem_rvalid one cycle after mem_req and an empty queue, of: AR handshake at cycle 0, mem_req at cycle 2, rvalid at cycle 4.
REQ-022 SHALL keep s_axi_rvalid low in every state other than RESP and ERR.

Reset
REQ-023 SHALL, on resetn low at any time including mid-burst, asynchronously force: FSM=IDLE; queue empty; beat_cnt=0; s_axi_arready=0 while resetn is low and 1 after release; s_axi_rvalid=0; s_axi_rlast=0; s_axi_rresp=00; s_axi_rid=0; s_axi_rdata=0; mem_req=0; mem_addr=0.
REQ-024 SHALL ignore any mem_rvalid that arrives after reset for a request issued before reset.

Configuration
REQ-025 SHALL, with macro AXI_RD_WRAP_EN defined, support WRAP(10) bursts: wrap_len=(len+1)<<size; boundary = addr aligned down to wrap_len; next = boundary + ((beat_addr + (1<<size) - boundary) mod wrap_len).
REQ-026 SHALL, with AXI_RD_WRAP_EN defined, treat WRAP with len not in {1,3,7,15} as illegal.
REQ-027 SHALL, without AXI_RD_WRAP_EN, treat every WRAP burst as illegal and respond to it with SLVERR beats.

Verification
REQ-028 SHALL verify INCR: AR addr=0x100, len=3, size=3, burst=01 -> mem_addr 0x100, 0x108, 0x110, 0x118; 4 OKAY beats; rlast on beat 4 only.
REQ-029 SHALL verify rready backpressure: rready held low 5 cycles on beat 2 -> rvalid and rdata held stable, no further mem_req until the handshake.
REQ-030 SHALL verify queue full: 4 ARs queued while the first burst stalls -> arready=0 on the 5th; a simultaneous pop and push keeps occupancy at 4.
REQ-031 SHALL verify an illegal burst: size=4 with DW=64, len=1 -> 2 SLVERR beats, rdata=0, mem_req never asserted.
REQ-032 SHALL verify WRAP with AXI_RD_WRAP_EN: addr=0x38, len=3, size=3 -> mem_addr 0x38, 0x20, 0x28, 0x30. Without the macro -> 4 SLVERR beats.
REQ-033 SHALL verify reset mid-burst: resetn pulsed low during beat 2 of 4, then a late mem_rvalid -> all outputs at reset values, no R beat emitted, next AR serviced normally.
